// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receive path.
// The sample struct describes one FIFO entry: channel flag plus audio word.
package i2s_rx_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic                    ch;
    logic [SAMPLE_WIDTH-1:0] data;
  } i2s_sample_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Generic synchronous FIFO with power-of-2 depth.
// Pointers carry one extra MSB so that level = wr_ptr - rd_ptr is exact.
module i2s_rx_fifo #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S target receiver: synchronizes pad signals, frames Philips-format words
// on WS transitions and queues {channel, word} entries for the consumer.
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic                          sd_i,
  output logic [WORD_WIDTH-1:0]         sample_o,
  output logic                          sample_ch_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          clear_ovf_i
);

  logic                  sck_s1, sck_s2, sck_s3;
  logic                  ws_s1, ws_s2;
  logic                  sd_s1, sd_s2;
  logic                  sck_rise;
  rx_state_e             state;
  logic                  ws_prev;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WORD_WIDTH-1:0] shift_next;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  word_done;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [WORD_WIDTH:0]   head;

  always_ff @(posedge clk) begin
    if (rst) begin
      {sck_s1, sck_s2, sck_s3} <= 3'b000;
      {ws_s1, ws_s2}           <= 2'b00;
      {sd_s1, sd_s2}           <= 2'b00;
    end else begin
      sck_s1 <= sck_i;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= ws_i;
      ws_s2  <= ws_s1;
      sd_s1  <= sd_i;
      sd_s2  <= sd_s1;
    end
  end

  assign sck_rise  = sck_s2 & ~sck_s3;
  assign word_done = sck_rise & (ws_s2 != ws_prev);
  assign push      = (state == RUN) & enable_i & word_done;
  assign pop       = sample_valid_o & sample_ready_i;

  // Bits past WORD_WIDTH fall off; short words stay left-justified.
  always_comb begin
    shift_next = shift_reg;
    if (bit_cnt < CNT_WIDTH'(WORD_WIDTH)) begin
      shift_next = shift_reg | (WORD_WIDTH'(sd_s2) << (WORD_WIDTH - 1 - int'(bit_cnt)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ws_prev   <= CH_LEFT;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (!enable_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= SYNC;
          ws_prev <= ws_s2;
        end
        SYNC: begin
          if (sck_rise) begin
            ws_prev <= ws_s2;
            if (word_done) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (sck_rise) begin
            ws_prev <= ws_s2;
            if (word_done) begin
              shift_reg <= '0;
              bit_cnt   <= '0;
            end else begin
              shift_reg <= shift_next;
              if (bit_cnt != CNT_WIDTH'(WORD_WIDTH)) begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a set in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow_o <= 1'b1;
    end else if (clear_ovf_i) begin
      overflow_o <= 1'b0;
    end
  end

  i2s_rx_fifo #(
    .DATA_WIDTH (WORD_WIDTH + 1),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ws_prev, shift_next}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level_o),
    .full      (full),
    .empty     (empty)
  );

  assign sample_valid_o = ~empty;
  assign sample_o       = head[WORD_WIDTH-1:0];
  assign sample_ch_o    = head[WORD_WIDTH];

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed/random bench for i2s_rx_deserializer: drives Philips I2S slots and
// checks delivered words against slot values justified to 16 bits.
module tb_i2s_rx_deserializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable_i = 1'b0;
  logic         sck_i = 1'b1;
  logic         ws_i = 1'b0;
  logic         sd_i = 1'b0;
  logic         sample_ready_i = 1'b0;
  logic         clear_ovf_i = 1'b0;
  logic [W-1:0] sample_o;
  logic         sample_ch_o;
  logic         sample_valid_o;
  logic [2:0]   fifo_level_o;
  logic         overflow_o;

  int          total = 0;
  int          bad = 0;
  logic [W:0]  exp_q[$];
  int          slot_ch[16];
  int unsigned slot_val[16];
  int          slot_len[16];
  int          n_slots = 0;
  int          dis_slot = -1;

  i2s_rx_deserializer dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .sck_i          (sck_i),
    .ws_i           (ws_i),
    .sd_i           (sd_i),
    .sample_o       (sample_o),
    .sample_ch_o    (sample_ch_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .fifo_level_o   (fifo_level_o),
    .overflow_o     (overflow_o),
    .clear_ovf_i    (clear_ovf_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A slot's word is its top 16 bits, or the whole slot padded with zeros below.
  function automatic logic [W:0] expect_word(input int ch, input int unsigned val, input int len);
    logic [63:0] v;
    v = 64'(val);
    if (len >= W) v = v >> (len - W);
    else          v = v << (W - len);
    return {ch[0], v[W-1:0]};
  endfunction

  task automatic set_slot(input int i, input int ch, input int unsigned val, input int len);
    slot_ch[i]  = ch;
    slot_val[i] = val;
    slot_len[i] = len;
  endtask

  task automatic expect_slot(input int i);
    exp_q.push_back(expect_word(slot_ch[i], slot_val[i], slot_len[i]));
  endtask

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic send_bit(input logic w, input logic d);
    #40 sck_i = 1'b0; ws_i = w; sd_i = d;
    #40 sck_i = 1'b1;
  endtask

  // WS switches on the last bit of each slot (one-bit delay before the next MSB).
  task automatic send_stream();
    logic nxt;
    logic d;
    logic w;
    enable_i = 1'b0;
    ws_i = slot_ch[0][0];
    #60 enable_i = 1'b1;
    #20;
    for (int i = 0; i < n_slots; i++) begin
      for (int b = 0; b < slot_len[i]; b++) begin
        nxt = (i + 1 < n_slots) ? slot_ch[i+1][0] : ~slot_ch[i][0];
        if (i == dis_slot && b == 4)  enable_i = 1'b0;
        if (i == dis_slot && b == 10) enable_i = 1'b1;
        d = slot_val[i][slot_len[i]-1-b];
        w = (b == slot_len[i] - 1) ? nxt : slot_ch[i][0];
        send_bit(w, d);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
    check({tag, "_level"}, 32'(fifo_level_o), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && sample_valid_o && sample_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {15'd0, sample_ch_o, sample_o}, 32'hFFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("word", {15'd0, sample_ch_o, sample_o}, {15'd0, e});
      end
    end
  end

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(sample_valid_o), 0);
    check("rst_level", 32'(fifo_level_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_sample", {15'd0, sample_ch_o, sample_o}, 0);
    rst = 1'b0;

    // three stereo frames; the leading partial slot is discarded
    sample_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) set_slot(i, i % 2, (i % 2) ? 32'h1234 : 32'hA5C3, 16);
    n_slots = 6;
    for (int i = 1; i < 6; i++) expect_slot(i);
    align();
    send_stream();
    wait_drain("stereo16");

    // long and short slots
    set_slot(0, 1, 32'h777, 24);
    set_slot(1, 0, 32'hABCDEF, 24);
    set_slot(2, 1, 32'h5A, 8);
    set_slot(3, 0, 32'hBEEF, 16);
    n_slots = 4;
    for (int i = 1; i < 4; i++) expect_slot(i);
    align();
    send_stream();
    wait_drain("mixed_len");

    // disable mid-word in slot 2, re-enable inside the same slot
    for (int i = 0; i < 6; i++) set_slot(i, i % 2, $urandom_range(0, 32'hFFFF), 16);
    n_slots = 6;
    dis_slot = 2;
    expect_slot(1);
    for (int i = 3; i < 6; i++) expect_slot(i);
    align();
    send_stream();
    dis_slot = -1;
    wait_drain("reenable");

    // six words into a stalled 4-entry FIFO: the first four survive
    sample_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) set_slot(i, i % 2, $urandom_range(0, 32'hFFFF), 16);
    n_slots = 7;
    for (int i = 1; i < 5; i++) expect_slot(i);
    align();
    send_stream();
    repeat (5) @(posedge clk);
    #1;
    check("full_level", 32'(fifo_level_o), 4);
    check("full_valid", 32'(sample_valid_o), 1);
    check("full_ovf", 32'(overflow_o), 1);
    check("head_word", {15'd0, sample_ch_o, sample_o}, {15'd0, exp_q[0]});
    clear_ovf_i = 1'b1;
    @(posedge clk);
    #1 clear_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 0);

    // clear held across the cycle of a dropped push: the set must win
    set_slot(0, 0, 32'h1111, 16);
    set_slot(1, 1, 32'h2222, 16);
    n_slots = 2;
    align();
    clear_ovf_i = 1'b1;
    send_stream();
    repeat (3) @(posedge clk);
    #1 clear_ovf_i = 1'b0;
    #20;
    check("ovf_set_wins", 32'(overflow_o), 1);
    check("ovf_level", 32'(fifo_level_o), 4);
    sample_ready_i = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 32'(overflow_o), 1);

    // reset with two queued words and a half-shifted word
    sample_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) set_slot(i, i % 2, $urandom_range(0, 32'hFFFF), 16);
    n_slots = 3;
    align();
    send_stream();
    for (int b = 0; b < 8; b++) send_bit(ws_i, 1'($urandom_range(0, 1)));
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_level", 32'(fifo_level_o), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_valid", 32'(sample_valid_o), 0);
    check("rst2_level", 32'(fifo_level_o), 0);
    check("rst2_ovf", 32'(overflow_o), 0);
    rst = 1'b0;

    // random slot lengths and data
    sample_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      len = $urandom_range(8, 24);
      set_slot(i, i % 2, $urandom_range(0, (1 << len) - 1), len);
    end
    n_slots = 10;
    for (int i = 1; i < 10; i++) expect_slot(i);
    align();
    send_stream();
    wait_drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
